// File: rtl/onehot_mux_pipe_if.sv
// onehot_mux_pipe_if: handshake and data bundle for onehot_mux_pipe.
//   master modport: producer/consumer side (drives in_valid, sel, din, out_ready, err_clr)
//   slave modport : mux side (drives in_ready, out_valid, dout, flags, error statistics)
//   in_valid/in_ready/sel/din        : input beat and handshake
//   out_valid/out_ready/dout/flags   : output beat and handshake
//   err_clr/err_sticky/err_count     : multi-hot error statistics
interface onehot_mux_pipe_if #(
   parameter int unsigned NUM_IN    = 8,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ERR_CNT_W = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [NUM_IN-1:0]       sel;
   logic [NUM_IN*WIDTH-1:0] din;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        dout;
   logic                    out_zero_hot;
   logic                    out_multi_hot;
   logic                    err_clr;
   logic                    err_sticky;
   logic [ERR_CNT_W-1:0]    err_count;

   modport master (
      output in_valid, sel, din, out_ready, err_clr,
      input  in_ready, out_valid, dout, out_zero_hot, out_multi_hot, err_sticky, err_count
   );

   modport slave (
      input  in_valid, sel, din, out_ready, err_clr,
      output in_ready, out_valid, dout, out_zero_hot, out_multi_hot, err_sticky, err_count
   );
endinterface

// File: rtl/onehot_mux_pipe.sv
// onehot_mux_pipe: parametrised AND/OR one-hot multiplexor with a 2-entry output FIFO,
// valid/ready handshake and saturating multi-hot error statistics.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset; clears FIFO contents, pointers and statistics
//   bus   : onehot_mux_pipe_if slave (input beat, output beat, error statistics)
module onehot_mux_pipe #(
   parameter int unsigned NUM_IN    = 8,
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ERR_CNT_W = 8
) (
   input logic              clk,
   input logic              rst_n,
   onehot_mux_pipe_if.slave bus
);

   logic [WIDTH-1:0]     mux_data;
   logic                 sel_seen;
   logic                 sel_multi;
   logic                 zero_hot;

   logic [WIDTH-1:0]     data_q [2];
   logic [1:0]           zero_q;
   logic [1:0]           multi_q;
   logic                 wr_ptr_q;
   logic                 rd_ptr_q;
   logic [1:0]           count_q;
   logic                 push;
   logic                 pop;

   logic                 err_sticky_q;
   logic [ERR_CNT_W-1:0] err_count_q;
   logic                 err_sat;

   // AND/OR mux; multi-hot is detected as "a set bit after one was already seen".
   always_comb begin
      mux_data  = '0;
      sel_seen  = 1'b0;
      sel_multi = 1'b0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         mux_data  = mux_data | ({WIDTH{bus.sel[i]}} & bus.din[i*WIDTH +: WIDTH]);
         sel_multi = sel_multi | (sel_seen & bus.sel[i]);
         sel_seen  = sel_seen | bus.sel[i];
      end
   end

   assign zero_hot = ~sel_seen;

   // Ready depends only on registered occupancy, never on out_ready.
   assign bus.in_ready  = (count_q != 2'd2);
   assign bus.out_valid = (count_q != 2'd0);
   assign push          = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q[0] <= '0;
         data_q[1] <= '0;
         zero_q    <= '0;
         multi_q   <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         if (push) begin
            data_q[wr_ptr_q]  <= mux_data;
            zero_q[wr_ptr_q]  <= zero_hot;
            multi_q[wr_ptr_q] <= sel_multi;
            wr_ptr_q          <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         if (push && !pop) begin
            count_q <= count_q + 2'd1;
         end else if (pop && !push) begin
            count_q <= count_q - 2'd1;
         end
      end
   end

   assign bus.dout          = data_q[rd_ptr_q];
   assign bus.out_zero_hot  = zero_q[rd_ptr_q];
   assign bus.out_multi_hot = multi_q[rd_ptr_q];

   assign err_sat = &err_count_q;

   // Statistics follow accepted beats; a new multi-hot event wins over a clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_sticky_q <= 1'b0;
         err_count_q  <= '0;
      end else if (push && sel_multi) begin
         err_sticky_q <= 1'b1;
         if (bus.err_clr) begin
            err_count_q <= ERR_CNT_W'(1);
         end else if (!err_sat) begin
            err_count_q <= err_count_q + ERR_CNT_W'(1);
         end
      end else if (bus.err_clr) begin
         err_sticky_q <= 1'b0;
         err_count_q  <= '0;
      end
   end

   assign bus.err_sticky = err_sticky_q;
   assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_onehot_mux_pipe.sv
// tb_onehot_mux_pipe: directed and random self-checking bench for onehot_mux_pipe
// (NUM_IN=8, WIDTH=32, ERR_CNT_W=2 so counter saturation is reachable quickly).
module tb_onehot_mux_pipe;

   localparam int unsigned NumIn = 8;
   localparam int unsigned Width = 32;
   localparam int unsigned ErrW  = 2;

   typedef struct packed {
      logic [31:0] data;
      logic        zh;
      logic        mh;
   } beat_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   onehot_mux_pipe_if #(.NUM_IN(NumIn), .WIDTH(Width), .ERR_CNT_W(ErrW)) bus ();

   onehot_mux_pipe #(
      .NUM_IN   (NumIn),
      .WIDTH    (Width),
      .ERR_CNT_W(ErrW)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic beat_t ref_beat(input logic [7:0] s, input logic [255:0] d);
      beat_t b;
      b.data = '0;
      for (int i = 0; i < 8; i++) begin
         if (s[i]) b.data = b.data | d[i*32 +: 32];
      end
      b.zh = (s == 8'h00);
      b.mh = ($countones(s) >= 2);
      return b;
   endfunction

   beat_t     q[$];
   beat_t     exp_b;
   int        m_cnt;
   logic      m_sticky;
   logic      acc;
   logic      pp;

   initial begin
      clk          = 1'b0;
      checks       = 0;
      failures     = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.sel      = '0;
      bus.din      = '0;
      bus.out_ready = 1'b0;
      bus.err_clr  = 1'b0;
      step();
      step();
      rst_n = 1'b1;

      // Reset state
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check_eq("rst_dout", bus.dout, 32'd0);
      check_eq("rst_zh", 32'(bus.out_zero_hot), 32'd0);
      check_eq("rst_mh", 32'(bus.out_multi_hot), 32'd0);
      check_eq("rst_err_count", 32'(bus.err_count), 32'd0);
      check_eq("rst_err_sticky", 32'(bus.err_sticky), 32'd0);

      // Basic select: din_i = 0x11111111*i, sel=0x04
      for (int i = 0; i < 8; i++) bus.din[i*32 +: 32] = 32'h1111_1111 * i;
      bus.sel       = 8'h04;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check_eq("basic_valid", 32'(bus.out_valid), 32'd1);
      check_eq("basic_dout", bus.dout, 32'h2222_2222);
      check_eq("basic_zh", 32'(bus.out_zero_hot), 32'd0);
      check_eq("basic_mh", 32'(bus.out_multi_hot), 32'd0);
      check_eq("basic_err_count", 32'(bus.err_count), 32'd0);
      step();
      check_eq("basic_drained", 32'(bus.out_valid), 32'd0);

      // Zero-hot
      bus.sel      = 8'h00;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check_eq("zero_dout", bus.dout, 32'd0);
      check_eq("zero_zh", 32'(bus.out_zero_hot), 32'd1);
      check_eq("zero_mh", 32'(bus.out_multi_hot), 32'd0);
      check_eq("zero_sticky", 32'(bus.err_sticky), 32'd0);
      step();

      // Multi-hot
      bus.din[1*32 +: 32] = 32'h0000_00F0;
      bus.din[2*32 +: 32] = 32'h0000_000F;
      bus.sel      = 8'h06;
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check_eq("multi_dout", bus.dout, 32'h0000_00FF);
      check_eq("multi_mh", 32'(bus.out_multi_hot), 32'd1);
      check_eq("multi_zh", 32'(bus.out_zero_hot), 32'd0);
      check_eq("multi_sticky", 32'(bus.err_sticky), 32'd1);
      check_eq("multi_count", 32'(bus.err_count), 32'd1);
      step();

      // Backpressure: A, B fill the FIFO, C is held off
      bus.din[0*32 +: 32] = 32'hA0A0_A0A0;
      bus.din[3*32 +: 32] = 32'hB0B0_B0B0;
      bus.din[7*32 +: 32] = 32'hC0C0_C0C0;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.sel       = 8'h01;
      step();
      check_eq("bp_ready_after_a", 32'(bus.in_ready), 32'd1);
      bus.sel = 8'h08;
      step();
      check_eq("bp_ready_full", 32'(bus.in_ready), 32'd0);
      check_eq("bp_dout_a", bus.dout, 32'hA0A0_A0A0);
      bus.sel = 8'h80;
      step();
      check_eq("bp_ready_held", 32'(bus.in_ready), 32'd0);
      check_eq("bp_dout_stable", bus.dout, 32'hA0A0_A0A0);
      bus.out_ready = 1'b1;
      step();
      check_eq("bp_dout_b", bus.dout, 32'hB0B0_B0B0);
      check_eq("bp_ready_recover", 32'(bus.in_ready), 32'd1);
      step();
      check_eq("bp_dout_c", bus.dout, 32'hC0C0_C0C0);
      check_eq("bp_valid_c", 32'(bus.out_valid), 32'd1);
      bus.in_valid = 1'b0;
      step();
      check_eq("bp_empty", 32'(bus.out_valid), 32'd0);

      // Saturation and clear
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      check_eq("clr_count", 32'(bus.err_count), 32'd0);
      check_eq("clr_sticky", 32'(bus.err_sticky), 32'd0);
      bus.sel      = 8'h06;
      bus.in_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         check_eq("sat_count", 32'(bus.err_count), (k < 3) ? 32'(k) : 32'd3);
         check_eq("sat_dout", bus.dout, 32'h0000_00FF);
      end
      bus.err_clr = 1'b1;
      step();
      check_eq("clr_evt_count", 32'(bus.err_count), 32'd1);
      check_eq("clr_evt_sticky", 32'(bus.err_sticky), 32'd1);
      bus.in_valid = 1'b0;
      step();
      bus.err_clr = 1'b0;
      check_eq("clr_alone_count", 32'(bus.err_count), 32'd0);
      check_eq("clr_alone_sticky", 32'(bus.err_sticky), 32'd0);
      step();

      // Reset mid-operation with two buffered beats and a multi-hot beat offered
      bus.out_ready = 1'b0;
      bus.sel       = 8'h08;
      bus.in_valid  = 1'b1;
      step();
      step();
      check_eq("mid_full", 32'(bus.in_ready), 32'd0);
      rst_n   = 1'b0;
      bus.sel = 8'h06;
      step();
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      check_eq("mid_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("mid_dout", bus.dout, 32'd0);
      check_eq("mid_in_ready", 32'(bus.in_ready), 32'd1);
      check_eq("mid_err_count", 32'(bus.err_count), 32'd0);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("mid_no_stale", 32'(bus.out_valid), 32'd0);
      end

      // Random soak against a queue model
      m_cnt    = 0;
      m_sticky = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         check_eq("soak_in_ready", 32'(bus.in_ready), 32'(q.size() != 2));
         check_eq("soak_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            check_eq("soak_dout", bus.dout, q[0].data);
            check_eq("soak_zh", 32'(bus.out_zero_hot), 32'(q[0].zh));
            check_eq("soak_mh", 32'(bus.out_multi_hot), 32'(q[0].mh));
         end
         check_eq("soak_err_count", 32'(bus.err_count), 32'(m_cnt));
         check_eq("soak_err_sticky", 32'(bus.err_sticky), 32'(m_sticky));

         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.err_clr   = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 3))
            0:       bus.sel = 8'h01 << $urandom_range(0, 7);
            1:       bus.sel = 8'h00;
            default: bus.sel = 8'($urandom);
         endcase
         for (int i = 0; i < 8; i++) bus.din[i*32 +: 32] = $urandom;

         exp_b = ref_beat(bus.sel, bus.din);
         acc   = bus.in_valid && (q.size() != 2);
         pp    = (q.size() != 0) && bus.out_ready;
         if (acc && exp_b.mh) begin
            m_sticky = 1'b1;
            m_cnt    = bus.err_clr ? 1 : ((m_cnt == 3) ? 3 : m_cnt + 1);
         end else if (bus.err_clr) begin
            m_sticky = 1'b0;
            m_cnt    = 0;
         end
         if (pp) void'(q.pop_front());
         if (acc) q.push_back(exp_b);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/onehot_mux_pipe.md
# onehot_mux_pipe

Parametrised, pipelined successor to the team's fixed 4-input AND/OR one-hot multiplexor. It generalises input count and data width, and adds a valid/ready handshake with a 2-entry output buffer. It classifies every select vector as one-hot, zero-hot or multi-hot and keeps saturating error statistics. It sits on datapath select points where the select and data arrive together and downstream may stall.

## Interface

- NUM_IN, default 8: number of data inputs; legal range 2..32.
- WIDTH, default 32: data width in bits; legal range 1..256.
- ERR_CNT_W, default 8: width of the multi-hot error counter.
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: reset, synchronous and active-low.
- in_valid  input  1: sel/din beat is valid.
- in_ready  output  1: block can accept a beat this cycle.
- sel  input  NUM_IN: select vector; bit i selects input i.
- din  input  NUM_IN*WIDTH: flattened data; input i occupies din[i*WIDTH +: WIDTH].
- out_valid  output  1: dout and flags are valid.
- out_ready  input  1: downstream accepts the output beat.
- dout  output  WIDTH: multiplexed result.
- out_zero_hot  output  1: the beat at the output had sel == 0.
- out_multi_hot  output  1: the beat at the output had two or more sel bits set.
- err_clr  input  1: clears err_sticky and err_count.
- err_sticky  output  1: set once any multi-hot beat has been accepted.
- err_count  output  ERR_CNT_W: number of accepted multi-hot beats, saturating.

## Operation

- **Accept:** a beat is accepted when in_valid && in_ready.
- **Data result:** the accepted beat is computed combinationally as the OR over i of ({WIDTH{sel[i]}} & din_i).
  - Zero-hot select gives all-zero data.
  - Multi-hot select gives the bitwise OR of the selected inputs. The result is deterministic and never X.
- **Flags:** computed at accept time.
  - zero_hot = ~|sel.
  - multi_hot = at least two sel bits set.
- **Buffer:** result and flags are written into a 2-entry FIFO.
  - Entry tracking uses a 2-bit occupancy count (0, 1, 2), a 1-bit write pointer and a 1-bit read pointer.
  - Pointers wrap 1 -> 0.
  - The output presents the read-pointer entry.
- **Ready and valid:**
  - in_ready = (occupancy != 2). in_ready is registered-derived only and has no combinational path from out_ready.
  - out_valid = (occupancy != 0).
  - A beat pops when out_valid && out_ready.
- **Occupancy update:**
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged, and both pointers advance.
  - Push while full cannot occur because in_ready is low.
- **Error statistics:** these count accepted beats, not beats popped.
  - On each accepted multi-hot beat, err_sticky <= 1 and err_count increments, saturating at 2^ERR_CNT_W - 1.
  - err_clr set alone: err_sticky <= 0 and err_count <= 0.
  - err_clr with an accepted multi-hot beat in the same cycle: err_sticky <= 1 and err_count <= 1. The new event wins over the clear.
- **Reset:** when rst_n == 0 at a rising edge:
  - Occupancy and pointers go to 0.
  - out_valid = 0 and in_ready = 1 in the next cycle.
  - err_sticky = 0 and err_count = 0.
  - Buffer data registers are also cleared, so dout = 0, out_zero_hot = 0 and out_multi_hot = 0.
  - Reset mid-operation discards all buffered beats. No beat is accepted or popped in a cycle with rst_n low.

## Timing

- Latency: a beat accepted at edge N is visible on out_valid/dout after edge N, i.e. one cycle, when the FIFO was empty or was popped the same cycle.
- Throughput: one beat per cycle while out_ready stays high.
- Stall: out_ready low for 2 cycles fills the FIFO. in_ready then drops in the cycle after the second accept.
- Recovery: the first pop re-asserts in_ready one cycle later.
- Output stability: dout and flags hold stable while out_valid && !out_ready.
- err_sticky and err_count update on the edge of acceptance.

## Test plan

- **Basic select:** NUM_IN=8, WIDTH=32, din_i = 32'h1111_1111*i, sel=8'h04, out_ready=1 -> next cycle dout=32'h2222_2222, out_zero_hot=0, out_multi_hot=0, err_count=0.
- **Zero-hot and multi-hot:**
  - sel=0 -> dout=0, out_zero_hot=1.
  - sel=8'h06 with din_1=32'h0000_00F0 and din_2=32'h0000_000F -> dout=32'h0000_00FF, out_multi_hot=1, err_sticky=1, err_count=1.
- **Backpressure:** out_ready=0 and 3 consecutive valid beats A, B, C -> A and B accepted, in_ready=0 while C is held. Release out_ready -> outputs A, B, C in order, with no loss or duplication.
- **Saturation and clear:**
  - ERR_CNT_W=2 and 5 multi-hot beats -> err_count=3.
  - err_clr together with a multi-hot beat -> err_count=1, err_sticky=1.
  - err_clr alone -> err_count=0, err_sticky=0.
- **Reset mid-operation:** FIFO holding 2 beats, rst_n low for 1 cycle -> out_valid=0, dout=0, in_ready=1, err_count=0. No stale beat appears afterwards.
- **Random soak:** random sel, din, in_valid and out_ready over 10k cycles -> scoreboard matches the AND/OR reference model, flags and counter exactly.
